// File: rtl/audioport_pkg.sv
// Shared types and defaults for the audio output path.
package audioport_pkg;

    localparam int FIFO_DEPTH       = 8;
    localparam int FIFO_PRIME_LEVEL = 4;
    localparam int AUDIO_WIDTH      = 24;

    typedef struct packed {
        logic [AUDIO_WIDTH-1:0] left;
        logic [AUDIO_WIDTH-1:0] right;
    } stereo_sample_t;

    typedef enum logic [1:0] {
        STANDBY = 2'd0,
        PRIMING = 2'd1,
        RUN     = 2'd2
    } fifo_state_t;

endpackage

// File: rtl/sync_fifo_core.sv
// Pointer-based synchronous FIFO: storage, wrap-bit pointers, registered level/full.
module sync_fifo_core #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 48
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [$clog2(DEPTH):0]   level_next
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW-1:0]    wr_ptr_n, rd_ptr_n;

    // A flush also swallows a write landing in the same cycle, leaving the FIFO empty.
    always_comb begin
        wr_ptr_n   = wr_ptr + PW'(push);
        rd_ptr_n   = flush ? wr_ptr_n : rd_ptr + PW'(pop);
        level_next = wr_ptr_n - rd_ptr_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
            level  <= level_next;
            full   <= (wr_ptr_n[AW] != rd_ptr_n[AW]) &&
                      (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);

endmodule

// File: rtl/i2s_sample_fifo.sv
// Stereo sample buffer feeding the I2S serializer: priming, request/tick handshake,
// underflow/overflow flags and flush on stop.
module i2s_sample_fifo
    import audioport_pkg::*;
#(
    parameter int DEPTH       = FIFO_DEPTH,
    parameter int DATA_WIDTH  = AUDIO_WIDTH,
    parameter int PRIME_LEVEL = FIFO_PRIME_LEVEL
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    play_in,
    input  logic                    clr_in,
    input  logic                    wr_in,
    input  logic [DATA_WIDTH-1:0]   wdata0_in,
    input  logic [DATA_WIDTH-1:0]   wdata1_in,
    output logic                    full_out,
    output logic [$clog2(DEPTH):0]  level_out,
    input  logic                    req_in,
    output logic                    tick_out,
    output logic [DATA_WIDTH-1:0]   audio0_out,
    output logic [DATA_WIDTH-1:0]   audio1_out,
    output logic                    underflow_out,
    output logic                    overflow_out
);

    localparam int PW = $clog2(DEPTH) + 1;

    fifo_state_t state, state_next;

    logic                    req_p1;
    logic                    req_rise, serve, flush, pop, push;
    logic                    uf_event, of_event;
    logic                    empty;
    logic [2*DATA_WIDTH-1:0] head;
    logic [PW-1:0]           level_next;

    logic                    vld_p1;
    logic [DATA_WIDTH-1:0]   audio0_p1, audio1_p1;
    logic                    uf_flag, of_flag;

    // Stopping from an active state wins over any request in the same cycle.
    always_comb begin
        req_rise = req_in & ~req_p1;
        flush    = ~play_in & (state != STANDBY);
        serve    = play_in & req_rise & (state != STANDBY);
        pop      = serve & (state == RUN) & ~empty;
        uf_event = serve & (state == RUN) & empty;
        push     = wr_in & (~full_out | pop);
        of_event = wr_in & ~push;
    end

    sync_fifo_core #(
        .DEPTH (DEPTH),
        .WIDTH (2*DATA_WIDTH)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .wdata      ({wdata0_in, wdata1_in}),
        .rdata      (head),
        .full       (full_out),
        .empty      (empty),
        .level      (level_out),
        .level_next (level_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= STANDBY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!play_in) begin
            state_next = STANDBY;
        end else begin
            case (state)
                STANDBY: state_next = PRIMING;
                PRIMING: if (level_next >= PW'(PRIME_LEVEL)) state_next = RUN;
                RUN:     state_next = RUN;
                default: state_next = STANDBY;
            endcase
        end
    end

    // Request edge detect -> tick/audio output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            req_p1    <= 1'b0;
            vld_p1    <= 1'b0;
            audio0_p1 <= '0;
            audio1_p1 <= '0;
        end else begin
            req_p1 <= req_in;
            vld_p1 <= serve;
            if (flush) begin
                audio0_p1 <= '0;
                audio1_p1 <= '0;
            end else if (serve) begin
                audio0_p1 <= pop ? head[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
                audio1_p1 <= pop ? head[DATA_WIDTH-1:0]            : '0;
            end
        end
    end

    // A fresh event in the clearing cycle keeps its flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            uf_flag <= 1'b0;
            of_flag <= 1'b0;
        end else begin
            uf_flag <= uf_event | (uf_flag & ~clr_in);
            of_flag <= of_event | (of_flag & ~clr_in);
        end
    end

    assign tick_out      = vld_p1;
    assign audio0_out    = audio0_p1;
    assign audio1_out    = audio1_p1;
    assign underflow_out = uf_flag;
    assign overflow_out  = of_flag;

endmodule

// File: tb/tb_i2s_sample_fifo.sv
// Directed bench for i2s_sample_fifo with a queue-based reference model checked every cycle.
module tb_i2s_sample_fifo;
    import audioport_pkg::*;

    localparam int DEPTH = 8;
    localparam int DW    = 24;
    localparam int PRIME = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          play = 1'b0, clr = 1'b0, wr = 1'b0, req = 1'b0;
    logic [DW-1:0] wd0 = '0, wd1 = '0;
    logic          full_out, tick_out, underflow_out, overflow_out;
    logic [3:0]    level_out;
    logic [DW-1:0] audio0_out, audio1_out;

    i2s_sample_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .PRIME_LEVEL(PRIME)) dut (
        .clk           (clk),
        .rst           (rst),
        .play_in       (play),
        .clr_in        (clr),
        .wr_in         (wr),
        .wdata0_in     (wd0),
        .wdata1_in     (wd1),
        .full_out      (full_out),
        .level_out     (level_out),
        .req_in        (req),
        .tick_out      (tick_out),
        .audio0_out    (audio0_out),
        .audio1_out    (audio1_out),
        .underflow_out (underflow_out),
        .overflow_out  (overflow_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: a queue of pairs plus a mode (0 standby, 1 priming, 2 run).
    stereo_sample_t q[$];
    int             mode = 0;
    bit             req_last = 1'b0;
    bit             started = 1'b0;
    logic           m_tick = 1'b0;
    logic [DW-1:0]  m_a0 = '0, m_a1 = '0;
    logic           m_uf = 1'b0, m_of = 1'b0;

    always @(posedge clk) begin : model
        bit rise, serve, uf_ev, of_ev;
        stereo_sample_t hd;
        started <= 1'b1;
        if (rst) begin
            q.delete();
            mode     <= 0;
            req_last <= 1'b0;
            m_tick   <= 1'b0;
            m_a0     <= '0;
            m_a1     <= '0;
            m_uf     <= 1'b0;
            m_of     <= 1'b0;
        end else begin
            rise  = req && !req_last;
            uf_ev = 1'b0;
            of_ev = 1'b0;
            req_last <= req;
            if (mode != 0 && !play) begin
                if (wr && q.size() == DEPTH) of_ev = 1'b1;
                q.delete();
                mode   <= 0;
                m_tick <= 1'b0;
                m_a0   <= '0;
                m_a1   <= '0;
            end else begin
                serve = (mode != 0) && play && rise;
                m_tick <= serve;
                if (serve) begin
                    if (mode == 2 && q.size() > 0) begin
                        hd = q.pop_front();
                        m_a0 <= hd.left;
                        m_a1 <= hd.right;
                    end else begin
                        m_a0 <= '0;
                        m_a1 <= '0;
                        if (mode == 2) uf_ev = 1'b1;
                    end
                end
                if (wr) begin
                    if (q.size() < DEPTH) q.push_back('{left: wd0, right: wd1});
                    else of_ev = 1'b1;
                end
                if (mode == 0 && play) mode <= 1;
                else if (mode == 1 && q.size() >= PRIME) mode <= 2;
            end
            m_uf <= uf_ev || (m_uf && !clr);
            m_of <= of_ev || (m_of && !clr);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_tick",      32'(tick_out),      32'(m_tick));
            chk("m_audio0",    32'(audio0_out),    32'(m_a0));
            chk("m_audio1",    32'(audio1_out),    32'(m_a1));
            chk("m_level",     32'(level_out),     32'(q.size()));
            chk("m_full",      32'(full_out),      32'(q.size() == DEPTH));
            chk("m_underflow", 32'(underflow_out), 32'(m_uf));
            chk("m_overflow",  32'(overflow_out),  32'(m_of));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
        wr = 1'b1; wd0 = a; wd1 = b;
        step();
        wr = 1'b0;
    endtask

    task automatic pulse_req();
        req = 1'b1;
        step();
        req = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst_level", 32'(level_out), 0);
        chk("rst_tick",  32'(tick_out), 0);
        chk("rst_audio0", 32'(audio0_out), 0);
        chk("rst_flags", 32'({underflow_out, overflow_out}), 0);

        // Prefill in standby, then prime and run
        for (int i = 1; i <= 4; i++) wr_pair(DW'(i), 24'h800000 | DW'(i));
        chk("prefill_level", 32'(level_out), 4);
        play = 1'b1;
        step(); step();
        pulse_req();
        chk("first_tick",   32'(tick_out), 1);
        chk("first_audio0", 32'(audio0_out), 32'h000001);
        chk("first_audio1", 32'(audio1_out), 32'h800001);
        chk("first_level",  32'(level_out), 3);
        step();
        for (int i = 2; i <= 4; i++) begin
            pulse_req();
            step();
        end
        chk("hold_audio0", 32'(audio0_out), 32'h000004);

        // Underflow, with clear in the same cycle as the event
        clr = 1'b1;
        pulse_req();
        clr = 1'b0;
        chk("uf_tick",   32'(tick_out), 1);
        chk("uf_audio0", 32'(audio0_out), 0);
        chk("uf_flag",   32'(underflow_out), 1);
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("uf_cleared", 32'(underflow_out), 0);

        // Reset mid-run with level 5
        for (int i = 0; i < 6; i++) wr_pair(24'h00a000 + DW'(i), 24'h00b000 + DW'(i));
        pulse_req();
        chk("mid_audio0", 32'(audio0_out), 32'h00a000);
        chk("mid_level",  32'(level_out), 5);
        step();
        rst = 1'b1;
        step(); step();
        chk("rst2_level",  32'(level_out), 0);
        chk("rst2_tick",   32'(tick_out), 0);
        chk("rst2_audio",  32'({audio0_out, audio1_out}), 0);
        rst = 1'b0;

        // Priming silence from empty
        step();
        for (int i = 0; i < 3; i++) begin
            pulse_req();
            chk("prime_tick",  32'(tick_out), 1);
            chk("prime_audio", 32'(audio0_out), 0);
            chk("prime_uf",    32'(underflow_out), 0);
            step();
        end
        for (int i = 0; i < 4; i++) wr_pair(24'h123400 + DW'(i), 24'h567800 + DW'(i));
        pulse_req();
        chk("run_audio0", 32'(audio0_out), 32'h123400);
        chk("run_audio1", 32'(audio1_out), 32'h567800);
        step();

        // Full boundary and overflow
        for (int i = 0; i < 5; i++) wr_pair(24'h0c0000 + DW'(i), 24'h0d0000 + DW'(i));
        chk("full_flag",  32'(full_out), 1);
        chk("full_level", 32'(level_out), 8);
        wr_pair(24'hdead00, 24'hbeef00);
        chk("of_flag",  32'(overflow_out), 1);
        chk("of_level", 32'(level_out), 8);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("of_cleared", 32'(overflow_out), 0);
        wr = 1'b1; wd0 = 24'h0e0000; wd1 = 24'h0f0000; req = 1'b1;
        step();
        wr = 1'b0; req = 1'b0;
        chk("wrpop_tick",  32'(tick_out), 1);
        chk("wrpop_audio", 32'(audio0_out), 32'h123401);
        chk("wrpop_level", 32'(level_out), 8);
        chk("wrpop_of",    32'(overflow_out), 0);
        step();

        // Stop flush with level 6 and a concurrent request
        pulse_req(); step();
        pulse_req(); step();
        chk("pre_stop_level", 32'(level_out), 6);
        play = 1'b0; req = 1'b1;
        step();
        req = 1'b0;
        chk("stop_level", 32'(level_out), 0);
        chk("stop_tick",  32'(tick_out), 0);
        chk("stop_audio", 32'(audio0_out), 0);
        step();
        pulse_req();
        chk("standby_tick", 32'(tick_out), 0);
        step();

        // Held request yields a single tick
        play = 1'b1;
        step(); step();
        req = 1'b1;
        step();
        chk("held_first", 32'(tick_out), 1);
        step();
        chk("held_second", 32'(tick_out), 0);
        step();
        req = 1'b0;
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t, expected finish earlier", $time);
        $fatal(1);
    end

endmodule
